// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, control inputs and the decode-side
// head-of-queue handshake. The fetch unit connects through the master modport.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int QDEPTH     = 4
);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [ADDR_WIDTH-1:0] ImemAddr;
    logic [DATA_WIDTH-1:0] ImemData;
    logic                  Halt;
    logic                  Redirect;
    logic [ADDR_WIDTH-1:0] RedirectPC;
    logic                  OutValid;
    logic                  OutReady;
    logic [DATA_WIDTH-1:0] OutInstr;
    logic [ADDR_WIDTH-1:0] OutPC;
    logic [ADDR_WIDTH-1:0] OutPCplus4;
    logic [CNT_W-1:0]      QCount;

    modport master (
        output ImemAddr, OutValid, OutInstr, OutPC, OutPCplus4, QCount,
        input  ImemData, Halt, Redirect, RedirectPC, OutReady
    );

    modport slave (
        input  ImemAddr, OutValid, OutInstr, OutPC, OutPCplus4, QCount,
        output ImemData, Halt, Redirect, RedirectPC, OutReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and buffers
// {PC, instruction} pairs in a small FIFO drained by decode via valid/ready.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4,
    parameter int                    QDEPTH     = 4
) (
    input logic          Clk,
    input logic          Reset,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(PC_STEP - 1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ADDR_WIDTH-1:0] pc_mem_q    [QDEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_q [QDEPTH];

    logic                  full;
    logic                  head_valid;
    logic                  pop;
    logic                  push;
    logic [ADDR_WIDTH-1:0] head_pc;

    assign full       = (count_q == CNT_W'(QDEPTH));
    assign head_valid = (count_q != '0);
    assign head_pc    = pc_mem_q[rd_ptr_q];

    // A redirecting consumer drops the head itself, so its handshake earns no pop.
    assign pop  = head_valid & bus.OutReady & ~bus.Redirect;
    assign push = ~bus.Halt & ~bus.Redirect & (~full | pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.Redirect) begin
            pc_d     = bus.RedirectPC & ALIGN_MASK;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + STEP;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; only the pointers and count qualify it.
    always_ff @(posedge Clk) begin
        if (Reset && push) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= bus.ImemData;
        end
    end

    assign bus.ImemAddr   = pc_q;
    assign bus.OutValid   = head_valid;
    assign bus.OutInstr   = instr_mem_q[rd_ptr_q];
    assign bus.OutPC      = head_pc;
    assign bus.OutPCplus4 = head_pc + STEP;
    assign bus.QCount     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 32-bit instance for the main scenarios
// and an 8-bit instance for PC wrap-around.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    logic rst8_n;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcp4;
    } exp_t;

    exp_t exp_q  [$];
    exp_t exp8_q [$];

    fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .QDEPTH(4)) bus ();
    fetch_unit_if #(.ADDR_WIDTH(8),  .DATA_WIDTH(32), .QDEPTH(4)) bus8 ();

    fetch_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4), .QDEPTH(4)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.master)
    );

    fetch_unit #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'h0), .PC_STEP(4), .QDEPTH(4)
    ) dut8 (
        .Clk   (clk),
        .Reset (rst8_n),
        .bus   (bus8.master)
    );

    function automatic logic [31:0] imem32(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] imem8(input logic [7:0] a);
        return {24'hC0FFEE, a};
    endfunction

    assign bus.ImemData  = imem32(bus.ImemAddr);
    assign bus8.ImemData = imem8(bus8.ImemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] pcp4);
        exp_t e;
        e.pc   = pc;
        e.pcp4 = pcp4;
        exp_q.push_back(e);
    endtask

    task automatic exp8_push(input logic [31:0] pc, input logic [31:0] pcp4);
        exp_t e;
        e.pc   = pc;
        e.pcp4 = pcp4;
        exp8_q.push_back(e);
    endtask

    // Monitors: a handshake seen at the negedge is the pop taken at the next posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.OutValid === 1'b1 && bus.OutReady === 1'b1
            && bus.Redirect === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop32", bus.OutPC, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_pc", bus.OutPC, e.pc);
                chk("pop_pcplus4", bus.OutPCplus4, e.pcp4);
                chk("pop_instr", bus.OutInstr, imem32(e.pc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst8_n === 1'b1 && bus8.OutValid === 1'b1 && bus8.OutReady === 1'b1
            && bus8.Redirect === 1'b0) begin
            if (exp8_q.size() == 0) begin
                chk("unexpected_pop8", {24'h0, bus8.OutPC}, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp8_q.pop_front();
                chk("pop8_pc", {24'h0, bus8.OutPC}, e.pc);
                chk("pop8_pcplus4", {24'h0, bus8.OutPCplus4}, e.pcp4);
                chk("pop8_instr", bus8.OutInstr, imem8(e.pc[7:0]));
            end
        end
    end

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        rst8_n          = 1'b0;
        bus.Halt        = 1'b0;
        bus.Redirect    = 1'b0;
        bus.RedirectPC  = '0;
        bus.OutReady    = 1'b0;
        bus8.Halt       = 1'b0;
        bus8.Redirect   = 1'b0;
        bus8.RedirectPC = '0;
        bus8.OutReady   = 1'b0;

        // Reset then free-run
        exp_push(32'd0, 32'd4);
        exp_push(32'd4, 32'd8);
        exp_push(32'd8, 32'd12);
        exp_push(32'd12, 32'd16);
        bus.OutReady = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid", 32'(bus.OutValid), 32'd0);
        chk("rst_qcount", 32'(bus.QCount), 32'd0);
        chk("rst_imemaddr", bus.ImemAddr, 32'd0);
        tick();
        chk("first_valid", 32'(bus.OutValid), 32'd1);
        chk("first_pc", bus.OutPC, 32'd0);
        repeat (4) tick();
        bus.OutReady = 1'b0;
        chk("freerun_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("bp_qcount_full", 32'(bus.QCount), 32'd4);
        chk("bp_imemaddr", bus.ImemAddr, 32'd16);
        tick();
        chk("bp_qcount_hold", 32'(bus.QCount), 32'd4);
        chk("bp_imemaddr_hold", bus.ImemAddr, 32'd16);
        exp_push(32'd0, 32'd4);
        exp_push(32'd4, 32'd8);
        exp_push(32'd8, 32'd12);
        exp_push(32'd12, 32'd16);
        exp_push(32'd16, 32'd20);
        bus.OutReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_qcount_stream", 32'(bus.QCount), 32'd4);
        end
        bus.OutReady = 1'b0;
        chk("bp_imemaddr_after", bus.ImemAddr, 32'd36);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Redirect with low-bit masking
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h103;
        tick();
        bus.Redirect = 1'b0;
        chk("rd_qcount", 32'(bus.QCount), 32'd0);
        chk("rd_imemaddr", bus.ImemAddr, 32'h100);
        chk("rd_valid_low", 32'(bus.OutValid), 32'd0);
        exp_push(32'h100, 32'h104);
        exp_push(32'h104, 32'h108);
        bus.OutReady = 1'b1;
        tick();
        chk("rd_valid", 32'(bus.OutValid), 32'd1);
        chk("rd_head_pc", bus.OutPC, 32'h100);
        tick();
        tick();
        bus.OutReady = 1'b0;
        chk("rd_drained", 32'(exp_q.size()), 32'd0);

        // Redirect colliding with a handshake on a non-full queue
        chk("sim_pre_qcount", 32'(bus.QCount), 32'd1);
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h200;
        bus.OutReady   = 1'b1;
        tick();
        bus.Redirect = 1'b0;
        bus.OutReady = 1'b0;
        chk("sim_qcount", 32'(bus.QCount), 32'd0);
        chk("sim_valid", 32'(bus.OutValid), 32'd0);
        chk("sim_imemaddr", bus.ImemAddr, 32'h200);
        tick();
        tick();
        chk("halt_pre_qcount", 32'(bus.QCount), 32'd2);

        // Halt still drains
        exp_push(32'h200, 32'h204);
        exp_push(32'h204, 32'h208);
        bus.Halt     = 1'b1;
        bus.OutReady = 1'b1;
        tick();
        tick();
        chk("halt_valid", 32'(bus.OutValid), 32'd0);
        chk("halt_qcount", 32'(bus.QCount), 32'd0);
        chk("halt_imemaddr", bus.ImemAddr, 32'h208);
        tick();
        tick();
        chk("halt_imemaddr_hold", bus.ImemAddr, 32'h208);
        chk("halt_valid_hold", 32'(bus.OutValid), 32'd0);
        bus.Halt     = 1'b0;
        bus.OutReady = 1'b0;
        chk("halt_drained", 32'(exp_q.size()), 32'd0);

        // Reset with a full queue
        repeat (4) tick();
        chk("mr_pre_qcount", 32'(bus.QCount), 32'd4);
        chk("mr_pre_imemaddr", bus.ImemAddr, 32'h218);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_qcount", 32'(bus.QCount), 32'd0);
        chk("mr_valid", 32'(bus.OutValid), 32'd0);
        chk("mr_imemaddr", bus.ImemAddr, 32'd0);
        exp_push(32'd0, 32'd4);
        exp_push(32'd4, 32'd8);
        bus.OutReady = 1'b1;
        tick();
        chk("mr_refetch_pc", bus.OutPC, 32'd0);
        tick();
        tick();
        bus.OutReady = 1'b0;
        chk("mr_drained", 32'(exp_q.size()), 32'd0);

        // PC wrap on the 8-bit instance
        rst8_n          = 1'b1;
        bus8.Redirect   = 1'b1;
        bus8.RedirectPC = 8'hFA;
        tick();
        bus8.Redirect = 1'b0;
        chk("wrap_imemaddr", {24'h0, bus8.ImemAddr}, 32'hF8);
        exp8_push(32'hF8, 32'hFC);
        exp8_push(32'hFC, 32'h00);
        exp8_push(32'h00, 32'h04);
        exp8_push(32'h04, 32'h08);
        bus8.OutReady = 1'b1;
        tick();
        chk("wrap_head_pc", {24'h0, bus8.OutPC}, 32'hF8);
        repeat (4) tick();
        bus8.OutReady = 1'b0;
        chk("wrap_drained", 32'(exp8_q.size()), 32'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage replacing the bare PC register, PC adder and instruction-memory wiring of the single-cycle core. It owns the program counter, drives the instruction-memory address, and buffers fetched instructions with their PCs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Branch/jump redirects flush the buffer and reload the PC. It sits between instruction memory and the controller/register-file decode logic.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, sequential PC increment; power of two
- QDEPTH, 4, fetch-queue entries; power of two, at least 2

- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- ImemAddr  out  ADDR_WIDTH  instruction-memory address; always equals the current PC
- ImemData  in  DATA_WIDTH  instruction at ImemAddr; combinational read, same cycle
- Halt  in  1  when 1, no fetch; PC holds
- Redirect  in  1  flush queue and load RedirectPC
- RedirectPC  in  ADDR_WIDTH  redirect target
- OutValid  out  1  queue head valid
- OutReady  in  1  decode accepts head
- OutInstr  out  DATA_WIDTH  head instruction
- OutPC  out  ADDR_WIDTH  head PC
- OutPCplus4  out  ADDR_WIDTH  head PC + PC_STEP, modulo 2^ADDR_WIDTH
- QCount  out  $clog2(QDEPTH+1)  current occupancy

## Operation
- **State:**
  - PC register.
  - QDEPTH-entry storage of {PC, instruction}.
  - Read and write pointers, each $clog2(QDEPTH) bits, wrapping naturally.
  - Occupancy counter.
- **Head outputs:**
  - OutValid = (QCount != 0).
  - OutInstr/OutPC come from the head entry.
  - OutPCplus4 is computed combinationally from OutPC.
  - Head outputs are don't-care when OutValid=0.
- **pop** = OutValid & OutReady & ~Redirect.
- **push** = ~Halt & ~Redirect & (QCount < QDEPTH | pop).
  - Push on a full queue is allowed only when a pop occurs in the same cycle.
- **On push:**
  - Write {PC, ImemData} at the write pointer.
  - Advance the write pointer.
  - PC <= PC + PC_STEP, modulo 2^ADDR_WIDTH. All-ones minus PC_STEP+1 wraps to 0.
- **On pop:** advance the read pointer.
- **Simultaneous push and pop:** QCount unchanged.
- **Redirect (priority over everything except Reset):**
  - Read pointer, write pointer and count are cleared.
  - PC <= RedirectPC with its low log2(PC_STEP) bits forced to 0.
  - No push occurs that cycle.
  - A concurrent OutValid&OutReady is void. The consumer issuing Redirect discards the head itself.
- **Halt with an empty queue:** OutValid stays 0 indefinitely. Halt does not block pops.
- **Reset (Reset=0 at a rising edge):**
  - PC = RESET_PC, pointers = 0, QCount = 0.
  - Reset overrides Redirect, Halt and handshakes.
  - Reset asserted mid-operation discards all queued entries.
- **Storage contents** are not reset; only the valid bookkeeping is.

## Timing
- **Reset values:**
  - ImemAddr = RESET_PC.
  - OutValid = 0.
  - QCount = 0.
  - OutInstr/OutPC/OutPCplus4 undefined until first push.
- **Fetch-to-valid latency:** 1 cycle. The instruction addressed in cycle t is at the head (if the queue was empty) in cycle t+1.
- **Redirect latency:**
  - Redirect sampled at edge t.
  - Target fetched during cycle t+1.
  - OutValid=1 with OutPC=target in cycle t+2.
- **Throughput:** one instruction per cycle with OutReady held high, including when the queue is full.
- **Combinational paths:**
  - OutReady to the push decision (full-queue case).
  - Redirect to push.
  - No path from ImemData to any output except through storage.
- **OutValid** never drops without a pop, Redirect or Reset.

## Test plan
- **Reset then free-run:** Reset=0 for 2 cycles, then 1, with OutReady=1 and RESET_PC=0. Require OutValid rising 1 cycle after release, then OutPC=0,4,8,12 on consecutive cycles and OutPCplus4=4,8,12,16.
- **Backpressure:** hold OutReady=0 from release. Require QCount to reach QDEPTH=4 after 4 cycles and ImemAddr to hold at 16. Then assert OutReady=1: QCount stays 4, and OutPC=0,4,8,12,16 are delivered with no gaps or duplicates.
- **Redirect:** in steady state, assert Redirect=1 with RedirectPC=0x103 for one cycle. Require QCount=0 next cycle and ImemAddr=0x100. OutValid=1 with OutPC=0x100 two cycles after assertion, followed by 0x104.
- **Simultaneous events:** Redirect, OutValid&OutReady and a non-full queue all in the same cycle. Require no push, no pop credit and all pointers cleared. Also Halt=1 with 2 entries and OutReady=1: require both drained, then OutValid=0 and ImemAddr constant.
- **PC wrap:** ADDR_WIDTH=8, redirect to 0xF8. Require OutPC sequence 0xF8, 0xFC, 0x00, 0x04, with OutPCplus4=0x00 for head 0xFC.
- **Reset mid-operation:** with the queue full, pull Reset=0 for one edge. Require QCount=0, OutValid=0 and ImemAddr=RESET_PC the next cycle, then normal refetch from RESET_PC.
